// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), segment encoding and
// helpers that derive the total line/frame lengths from the four segments.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Segment order along either axis: active, front porch, sync, back porch.
  typedef enum logic [1:0] {
    SegActive,
    SegFrontPorch,
    SegSync,
    SegBackPorch
  } vga_seg_e;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned h_total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int unsigned v_total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  localparam int unsigned H_TOTAL_DEF = h_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = v_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: a wrapping position counter that advances on
// en_i, flags its last position, and decodes active/sync segments.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o
);

  localparam int unsigned Total = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] FpStart   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SyncStart = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BpStart   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  vga_seg_e         seg;

  assign wrap_o = en_i & (cnt_q == LastCnt);

  // Next position: hold, step, or wrap to zero after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Position register, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Segment decode; later segments win so zero-length segments collapse.
  always_comb begin
    seg = SegActive;
    if (cnt_q >= BpStart) begin
      seg = SegBackPorch;
    end else if (cnt_q >= SyncStart) begin
      seg = SegSync;
    end else if (cnt_q >= FpStart) begin
      seg = SegFrontPorch;
    end
  end

  assign cnt_o    = cnt_q;
  assign active_o = (seg == SegActive);
  assign sync_o   = (seg == SegSync);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, pixel
// requests to an external source, and a two-stage pipeline that keeps the
// returned colour aligned with the sync outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned CNT_W    = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COLOR_W-1:0] PIX_R,
  input  logic [COLOR_W-1:0] PIX_G,
  input  logic [COLOR_W-1:0] PIX_B,
  output logic               PIX_REQ,
  output logic [CNT_W-1:0]   PIX_X,
  output logic [CNT_W-1:0]   PIX_Y,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0]  div_q, div_d;
  logic             tick;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
  logic             frame_top_q, frame_top_d;

  // Stage 1: counter-derived state captured on the tick.
  logic s1_valid_q, s1_active_q, s1_hs_q, s1_vs_q;

  // Tick on divider phase zero, so the first cycle after reset is a tick.
  assign tick = (div_q == '0) & ~RST;

  // Divider next state: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_d = div_q + DivW'(1);
    if (RST || div_q == DivLast) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge CLK) begin
    div_q <= div_d;
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .en_i     (tick),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .active_o (h_active),
    .sync_o   (h_sync)
  );

  // Vertical axis steps only on the horizontal wrap, so sync covers whole lines.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .en_i     (h_wrap),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap),
    .active_o (v_active),
    .sync_o   (v_sync)
  );

  // Tracks "on line 0" so FRAME_START needs no wide compare on v_cnt.
  always_comb begin
    frame_top_d = frame_top_q;
    if (v_wrap) begin
      frame_top_d = 1'b1;
    end else if (h_wrap) begin
      frame_top_d = 1'b0;
    end
  end

  // First-line flag register; reset lands on line 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_top_q <= 1'b1;
    end else begin
      frame_top_q <= frame_top_d;
    end
  end

  assign PIX_REQ     = tick & h_active & v_active;
  assign PIX_X       = h_cnt;
  assign PIX_Y       = v_cnt;
  assign LINE_START  = tick & (h_cnt == '0);
  assign FRAME_START = tick & (h_cnt == '0) & frame_top_q;

  // Stage 1: capture blanking and sync levels for the tick being requested.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_active_q <= 1'b0;
      s1_hs_q     <= ~HS_POL;
      s1_vs_q     <= ~VS_POL;
    end else begin
      s1_valid_q <= tick;
      if (tick) begin
        s1_active_q <= h_active & v_active;
        s1_hs_q     <= h_sync ? HS_POL : ~HS_POL;
        s1_vs_q     <= v_sync ? VS_POL : ~VS_POL;
      end
    end
  end

  // Stage 2: register returned colour together with sync; hold otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= ~HS_POL;
      VGA_VS <= ~VS_POL;
    end else if (s1_valid_q) begin
      VGA_R  <= s1_active_q ? PIX_R : '0;
      VGA_G  <= s1_active_q ? PIX_G : '0;
      VGA_B  <= s1_active_q ? PIX_B : '0;
      VGA_HS <= s1_hs_q;
      VGA_VS <= s1_vs_q;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing over two lines, a reduced-size
// raster over two frames plus mid-frame reset, and a tiny high-polarity mode.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default-parameter instance with a modelled pixel source.
  logic       rst_d = 1'b1;
  logic [3:0] pix_r = 4'hF, pix_g = 4'hF, pix_b = 4'hF;
  logic       dd_req, dd_ls, dd_fs, dd_hs, dd_vs;
  logic [9:0] dd_x, dd_y;
  logic [3:0] dd_r, dd_g, dd_b;

  vga_timing_gen dut_d (
    .CLK(clk), .RST(rst_d), .PIX_R(pix_r), .PIX_G(pix_g), .PIX_B(pix_b),
    .PIX_REQ(dd_req), .PIX_X(dd_x), .PIX_Y(dd_y), .LINE_START(dd_ls),
    .FRAME_START(dd_fs), .VGA_R(dd_r), .VGA_G(dd_g), .VGA_B(dd_b),
    .VGA_HS(dd_hs), .VGA_VS(dd_vs)
  );

  // Pixel source: answers a request with (x, y, C) in the next cycle, junk otherwise.
  always begin : pix_source
    logic [9:0] sx, sy;
    @(negedge clk);
    #2;
    if (dd_req === 1'b1) begin
      sx = dd_x;
      sy = dd_y;
      @(posedge clk);
      #1;
      pix_r = sx[3:0];
      pix_g = sy[3:0];
      pix_b = 4'hC;
      @(posedge clk);
      #1;
      pix_r = 4'hF;
      pix_g = 4'hF;
      pix_b = 4'hF;
    end
  end

  // Reduced raster: H 16/2/4/3 (25), V 12/2/2/3 (19), line 50 CLK, frame 950 CLK.
  logic       rst_m = 1'b1;
  logic       dm_req, dm_ls, dm_fs, dm_hs, dm_vs;
  logic [9:0] dm_x, dm_y;
  logic [3:0] dm_r, dm_g, dm_b;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_m (
    .CLK(clk), .RST(rst_m), .PIX_R(4'hA), .PIX_G(4'h5), .PIX_B(4'h3),
    .PIX_REQ(dm_req), .PIX_X(dm_x), .PIX_Y(dm_y), .LINE_START(dm_ls),
    .FRAME_START(dm_fs), .VGA_R(dm_r), .VGA_G(dm_g), .VGA_B(dm_b),
    .VGA_HS(dm_hs), .VGA_VS(dm_vs)
  );

  // Small mode: H 4/1/1/1 (7), V 3/1/1/1 (6), CLK_DIV 3, high-active syncs.
  logic       rst_s = 1'b1;
  logic       ds_req, ds_ls, ds_fs, ds_hs, ds_vs;
  logic [9:0] ds_x, ds_y;
  logic [3:0] ds_r, ds_g, ds_b;

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .CLK(clk), .RST(rst_s), .PIX_R(4'h5), .PIX_G(4'h6), .PIX_B(4'h7),
    .PIX_REQ(ds_req), .PIX_X(ds_x), .PIX_Y(ds_y), .LINE_START(ds_ls),
    .FRAME_START(ds_fs), .VGA_R(ds_r), .VGA_G(ds_g), .VGA_B(ds_b),
    .VGA_HS(ds_hs), .VGA_VS(ds_vs)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({dd_r, dd_g, dd_b} !== 12'h000) begin
      bad++; $display("FAIL reset_rgb got %h exp 000", {dd_r, dd_g, dd_b});
    end
    total++;
    if ({dd_hs, dd_vs} !== 2'b11) begin
      bad++; $display("FAIL reset_sync got %b exp 11", {dd_hs, dd_vs});
    end
    total++;
    if ({dd_req, dd_ls, dd_fs} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got %b exp 000", {dd_req, dd_ls, dd_fs});
    end
    // Release: the very first cycle must already be the (0,0) tick.
    @(negedge clk);
    rst_d = 1'b0;
    #1;
    total++;
    if ({dd_req, dd_ls, dd_fs} !== 3'b111) begin
      bad++; $display("FAIL first_tick_strobes got %b exp 111", {dd_req, dd_ls, dd_fs});
    end
    total++;
    if (dd_x !== 10'd0 || dd_y !== 10'd0) begin
      bad++; $display("FAIL first_tick_xy got (%0d,%0d) exp (0,0)", dd_x, dd_y);
    end
  endtask

  // Cycle c = 0 is the release cycle; every cycle checked against closed forms.
  task automatic test_two_lines();
    int cl, ln;
    logic ereq, els, efs, ehs;
    logic [3:0] er, eg, eb;
    for (int c = 0; c <= 3200; c++) begin
      #1;
      cl   = c % 1600;
      ln   = c / 1600;
      ereq = (c % 2 == 0) && (cl < 1280);
      els  = (cl == 0);
      efs  = (c == 0);
      ehs  = !(cl >= 1314 && cl < 1506);
      if (cl >= 2 && cl < 1282) begin
        er = 4'((cl - 2) / 2);
        eg = 4'(ln);
        eb = 4'hC;
      end else begin
        er = 4'h0;
        eg = 4'h0;
        eb = 4'h0;
      end
      total++;
      if (dd_req !== ereq) begin
        bad++; $display("FAIL line_req c=%0d got %b exp %b", c, dd_req, ereq);
      end
      if (ereq) begin
        total++;
        if (dd_x !== 10'(cl / 2) || dd_y !== 10'(ln)) begin
          bad++;
          $display("FAIL line_xy c=%0d got (%0d,%0d) exp (%0d,%0d)", c, dd_x, dd_y, cl / 2, ln);
        end
      end
      total++;
      if (dd_ls !== els || dd_fs !== efs) begin
        bad++;
        $display("FAIL line_starts c=%0d got ls=%b fs=%b exp ls=%b fs=%b",
                 c, dd_ls, dd_fs, els, efs);
      end
      total++;
      if (dd_hs !== ehs || dd_vs !== 1'b1) begin
        bad++;
        $display("FAIL line_sync c=%0d got hs=%b vs=%b exp hs=%b vs=1", c, dd_hs, dd_vs, ehs);
      end
      total++;
      if (dd_r !== er || dd_g !== eg || dd_b !== eb) begin
        bad++;
        $display("FAIL line_rgb c=%0d got %h%h%h exp %h%h%h", c, dd_r, dd_g, dd_b, er, eg, eb);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_two_frames();
    int fs_cnt = 0, req0 = 0, req1 = 0, last_c = -1, vs_low = 0, vs_first = -1;
    int hs_low = 0, hs_first = -1, r_on = 0, first_req_c = -1;
    logic [9:0] last_x = '0, last_y = '0;
    rst_m = 1'b1;
    repeat (2) @(negedge clk);
    rst_m = 1'b0;
    for (int c = 0; c <= 1900; c++) begin
      #1;
      if (dm_fs) fs_cnt++;
      if (dm_req) begin
        if (c < 950) begin
          req0++;
          last_c = c;
          last_x = dm_x;
          last_y = dm_y;
          if (first_req_c < 0) first_req_c = c;
        end else if (c < 1900) begin
          req1++;
        end
      end
      if (c < 950) begin
        if (!dm_vs) begin
          vs_low++;
          if (vs_first < 0) vs_first = c;
        end
        if (dm_r == 4'hA) r_on++;
      end
      if (c < 50 && !dm_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = c;
      end
      if (c == 950 || c == 1900) begin
        total++;
        if (dm_fs !== 1'b1 || dm_ls !== 1'b1 || dm_x !== 10'd0 || dm_y !== 10'd0) begin
          bad++;
          $display("FAIL frame_wrap c=%0d got fs=%b ls=%b (%0d,%0d) exp fs=1 ls=1 (0,0)",
                   c, dm_fs, dm_ls, dm_x, dm_y);
        end
      end
      @(negedge clk);
    end
    total++;
    if (fs_cnt != 3) begin bad++; $display("FAIL frame_count got %0d exp 3", fs_cnt); end
    total++;
    if (req0 != 192 || req1 != 192) begin
      bad++; $display("FAIL frame_reqs got %0d/%0d exp 192/192", req0, req1);
    end
    total++;
    if (first_req_c != 0) begin
      bad++; $display("FAIL frame_first_req got c=%0d exp c=0", first_req_c);
    end
    total++;
    if (last_c != 580 || last_x !== 10'd15 || last_y !== 10'd11) begin
      bad++;
      $display("FAIL frame_last_req got c=%0d (%0d,%0d) exp c=580 (15,11)", last_c, last_x, last_y);
    end
    total++;
    if (vs_low != 100 || vs_first != 702) begin
      bad++; $display("FAIL frame_vs got len=%0d at=%0d exp len=100 at=702", vs_low, vs_first);
    end
    total++;
    if (hs_low != 8 || hs_first != 38) begin
      bad++; $display("FAIL frame_hs got len=%0d at=%0d exp len=8 at=38", hs_low, hs_first);
    end
    total++;
    if (r_on != 384) begin bad++; $display("FAIL frame_colour_cycles got %0d exp 384", r_on); end
  endtask

  // Reset pulse at pixel (10,7) of the reduced raster, tick cycle c = 370.
  task automatic test_reset_midframe();
    rst_m = 1'b1;
    repeat (2) @(negedge clk);
    rst_m = 1'b0;
    repeat (370) @(negedge clk);
    #1;
    total++;
    if (dm_req !== 1'b1 || dm_x !== 10'd10 || dm_y !== 10'd7 || dm_r !== 4'hA) begin
      bad++;
      $display("FAIL mid_pos got req=%b (%0d,%0d) r=%h exp req=1 (10,7) r=a",
               dm_req, dm_x, dm_y, dm_r);
    end
    rst_m = 1'b1;
    #1;
    total++;
    if ({dm_req, dm_ls, dm_fs} !== 3'b000) begin
      bad++; $display("FAIL mid_rst_strobes got %b exp 000", {dm_req, dm_ls, dm_fs});
    end
    @(negedge clk);
    #1;
    total++;
    if ({dm_r, dm_g, dm_b} !== 12'h000 || {dm_hs, dm_vs} !== 2'b11) begin
      bad++;
      $display("FAIL mid_rst_outputs got rgb=%h hs=%b vs=%b exp rgb=000 hs=1 vs=1",
               {dm_r, dm_g, dm_b}, dm_hs, dm_vs);
    end
    rst_m = 1'b0;
    #1;
    total++;
    if ({dm_req, dm_ls, dm_fs} !== 3'b111 || dm_x !== 10'd0 || dm_y !== 10'd0) begin
      bad++;
      $display("FAIL mid_restart got strobes=%b (%0d,%0d) exp 111 (0,0)",
               {dm_req, dm_ls, dm_fs}, dm_x, dm_y);
    end
    @(negedge clk);
  endtask

  task automatic test_small_mode();
    int fs_cnt = 0, hs_hi = 0, hs_first = -1, vs_hi = 0, vs_first = -1, r_on = 0, reqs = 0;
    #1;
    total++;
    if ({ds_hs, ds_vs} !== 2'b00 || ds_r !== 4'h0 || ds_req !== 1'b0) begin
      bad++;
      $display("FAIL small_reset got hs=%b vs=%b r=%h req=%b exp 0 0 0 0",
               ds_hs, ds_vs, ds_r, ds_req);
    end
    @(negedge clk);
    rst_s = 1'b0;
    for (int c = 0; c <= 252; c++) begin
      #1;
      if (ds_fs) begin
        fs_cnt++;
        total++;
        if (c != 0 && c != 126 && c != 252) begin
          bad++; $display("FAIL small_fs_pos got c=%0d exp 0/126/252", c);
        end
      end
      if (c < 21 && ds_hs) begin
        hs_hi++;
        if (hs_first < 0) hs_first = c;
      end
      if (c < 126) begin
        if (ds_vs) begin
          vs_hi++;
          if (vs_first < 0) vs_first = c;
        end
        if (ds_r == 4'h5) r_on++;
        if (ds_req) reqs++;
      end
      @(negedge clk);
    end
    total++;
    if (fs_cnt != 3) begin bad++; $display("FAIL small_fs_count got %0d exp 3", fs_cnt); end
    total++;
    if (hs_hi != 3 || hs_first != 17) begin
      bad++; $display("FAIL small_hs got len=%0d at=%0d exp len=3 at=17", hs_hi, hs_first);
    end
    total++;
    if (vs_hi != 21 || vs_first != 86) begin
      bad++; $display("FAIL small_vs got len=%0d at=%0d exp len=21 at=86", vs_hi, vs_first);
    end
    total++;
    if (reqs != 12 || r_on != 36) begin
      bad++; $display("FAIL small_pixels got req=%0d colour=%0d exp 12 36", reqs, r_on);
    end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_two_frames();
    test_reset_midframe();
    test_small_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named CLK and RST.
REQ-002 Parameters (name, default, meaning), one per line:
- CLK_DIV, 2, CLK cycles per pixel, legal range >=2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, asserted level of VGA_HS.
- VS_POL, 0, asserted level of VGA_VS.
- COLOR_W, 4, bits per colour channel.
- CNT_W, 10, counter width, must hold H_TOTAL-1 and V_TOTAL-1.
REQ-003 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1, system clock.
- RST, in, 1, synchronous active-high reset.
- PIX_R / PIX_G / PIX_B, in, COLOR_W each, colour returned by the pixel source.
- PIX_REQ, out, 1, pixel request strobe.
- PIX_X, out, CNT_W, column of the requested pixel.
- PIX_Y, out, CNT_W, row of the requested pixel.
- LINE_START, out, 1, one-CLK pulse at the start of each line.
- FRAME_START, out, 1, one-CLK pulse at the start of each frame.
- VGA_R / VGA_G / VGA_B, out, COLOR_W each, DAC colour.
- VGA_HS, out, 1, horizontal sync.
- VGA_VS, out, 1, vertical sync.

Function
REQ-004 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 SHALL generate a pixel tick on every CLK_DIV-th CLK cycle; the first tick after reset release SHALL occur on the first cycle.
REQ-006 On each tick, h_cnt SHALL advance 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL advance only on h wrap, over 0..V_TOTAL-1, then wrap to 0.
REQ-007 Per line, segment order SHALL be active, then front porch, then sync, then back porch; the same order SHALL apply vertically.
REQ-008 Horizontal sync SHALL be asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-009 Vertical sync SHALL be asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines.
REQ-010 Asserted sync level SHALL equal HS_POL / VS_POL; deasserted level SHALL be the inverse.
REQ-011 Request timing:
- PIX_REQ SHALL be high for exactly the tick cycle when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- PIX_X = h_cnt and PIX_Y = v_cnt SHALL be valid whenever PIX_REQ is high.
REQ-012 The pixel source SHALL present PIX_R/G/B in the CLK cycle after PIX_REQ; the block SHALL register them on the edge ending that cycle.
REQ-013 VGA_HS, VGA_VS and VGA_R/G/B SHALL update on the same edge (2 CLK after the counter state), so colour and sync stay aligned. Between updates they SHALL hold.
REQ-014 During blanking, VGA_R/G/B SHALL be registered as zero regardless of PIX_*.
REQ-015 LINE_START SHALL pulse on the tick with h_cnt==0.
REQ-016 FRAME_START SHALL pulse on the tick with h_cnt==0 and v_cnt==0; at this point LINE_START also pulses.
REQ-017 Simultaneous h and v wrap SHALL produce (0,0) on the next tick, with no skipped or duplicated line.

Reset
REQ-018 RST high SHALL clear the divider, h_cnt and v_cnt, regardless of current position.
REQ-019 During reset: VGA_R/G/B=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, and PIX_REQ, LINE_START, FRAME_START all 0.
REQ-020 After release, the first tick SHALL be pixel (0,0) with FRAME_START=1.

Structure
REQ-021 A shared package vga_pkg SHALL hold the default 640x480@60 timing constants and the derived H_TOTAL/V_TOTAL functions.
REQ-022 Sub-module vga_axis_counter (parametrised ACTIVE/FP/SYNC/BP, with enable, wrap-out and sync flag) SHALL be instanced once per axis.

Verification
REQ-023 Defaults, reset then run 2 frames:
- Line period 1600 CLK; frame period 840000 CLK.
- VGA_HS low for 192 CLK per line.
- VGA_VS low for 3200 CLK per frame.
REQ-024 Defaults: 307200 PIX_REQ per frame; first PIX_REQ at (0,0); last at (639,479).
REQ-025 Source returns PIX_R = PIX_X[3:0]:
- VGA_R sequence 0,1,..,15,0 appears 2 CLK after the matching requests.
- VGA_R=0 throughout blanking.
REQ-026 Small mode (4/1/1/1, 3/1/1/1, CLK_DIV=3, HS_POL=VS_POL=1): H_TOTAL=7, V_TOTAL=6, high-active syncs, FRAME_START every 126 CLK.
REQ-027 Assert RST for one cycle at (300,200):
- Outputs return to reset values on the next edge.
- The next tick is (0,0) with FRAME_START=1.
